parameterized_decade_down_counter: RTL and testbench

Loadable multi-digit BCD countdown counter, the down-counting counterpart of the team's up-counting decade counter. Software or a control FSM loads a start value. The block then decrements once per enabled cycle with per-digit borrow ripple, signals zero with a level and a one-cycle pulse, and stops. It sits in timer and timeout paths where the up counter's terminal-count style is needed in reverse.

---
 rtl/parameterized_decade_down_counter_pkg.sv | 23 ++
 rtl/decade_down_digit.sv | 35 +++
 rtl/parameterized_decade_down_counter.sv | 130 +++++++++++++
 tb/tb_parameterized_decade_down_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/parameterized_decade_down_counter_pkg.sv
// Shared types and helpers for the BCD countdown counter: run state, digit clamp, zero test.
// Pure declarations; no timing or flow-control behaviour of its own.
package parameterized_decade_down_counter_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_MODULO = 10;
  localparam int unsigned DEF_DIGITS = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturate an out-of-range digit field to the largest legal digit.
  function automatic int unsigned clamp_digit(input int unsigned val, input int unsigned modulo);
    return (val >= modulo) ? (modulo - 1) : val;
  endfunction

  function automatic logic is_zero(input logic [63:0] val);
    return (val == 64'd0);
  endfunction

endpackage

// File: rtl/decade_down_digit.sv
// One BCD-style down-counting digit: load wins, else decrement on borrow_in with wrap to MODULO-1.
// One-cycle update; no backpressure, borrow_out is combinational from the held digit.
module decade_down_digit
  import parameterized_decade_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MODULO = DEF_MODULO
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_dat,
  input  logic             i_borrow_in,
  output logic             o_borrow_out,
  output logic [WIDTH-1:0] o_digit
);

  logic [WIDTH-1:0] r_digit;
  logic             w_at_zero;

  assign w_at_zero    = is_zero(64'(r_digit));
  assign o_borrow_out = w_at_zero & i_borrow_in;
  assign o_digit      = r_digit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_dat;
    end else if (i_borrow_in) begin
      r_digit <= w_at_zero ? WIDTH'(MODULO - 1) : (r_digit - WIDTH'(1));
    end
  end

endmodule

// File: rtl/parameterized_decade_down_counter.sv
// Loadable multi-digit BCD countdown with zero level (tc) and registered one-cycle done pulse; optional reload under DECADE_DOWN_AUTORELOAD_EN.
// Load/decrement take effect at the sampling edge; no backpressure, i_enable simply gates decrements while running.
module parameterized_decade_down_counter
  import parameterized_decade_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MODULO = DEF_MODULO,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [DIGITS*WIDTH-1:0] i_load_value,
  input  logic                    i_enable,
  input  logic                    i_auto_reload,
  output logic [DIGITS*WIDTH-1:0] o_count,
  output logic                    o_busy,
  output logic                    o_tc,
  output logic                    o_done
);

  localparam int unsigned CW = DIGITS * WIDTH;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_done;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_load_clamped;
  logic [CW-1:0]    w_dig_dat;
  logic             w_dig_load;
  logic             w_load_zero;
  logic             w_dec;
  logic             w_count_one;
  logic             w_expire;
  logic             w_reload_fire;
  logic [DIGITS:0]  w_borrow;
  logic             w_unused;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
    assign w_load_clamped[gi*WIDTH +: WIDTH] =
      WIDTH'(clamp_digit(32'(i_load_value[gi*WIDTH +: WIDTH]), MODULO));
  end

  assign w_load_zero = is_zero(64'(w_load_clamped));
  assign w_dec       = (r_state == ST_RUN) & i_enable & ~i_load;
  assign w_count_one = (w_count == CW'(1));
  // Expiry is the decrement that lands on zero; load already excluded by w_dec.
  assign w_expire    = w_dec & w_count_one;

`ifdef DECADE_DOWN_AUTORELOAD_EN
  logic [CW-1:0] r_reload_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reload_dat <= '0;
    end else if (i_load) begin
      r_reload_dat <= w_load_clamped;
    end
  end

  assign w_reload_fire = w_expire & i_auto_reload & ~is_zero(64'(r_reload_dat));
  assign w_dig_dat     = i_load ? w_load_clamped : r_reload_dat;
  assign w_unused      = w_borrow[DIGITS];
`else
  assign w_reload_fire = 1'b0;
  assign w_dig_dat     = w_load_clamped;
  assign w_unused      = w_borrow[DIGITS] ^ i_auto_reload;
`endif

  assign w_dig_load = i_load | w_reload_fire;
  assign w_borrow[0] = w_dec;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    decade_down_digit #(
      .WIDTH  (WIDTH),
      .MODULO (MODULO)
    ) u_digit (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (w_dig_load),
      .i_load_dat   (w_dig_dat[gi*WIDTH +: WIDTH]),
      .i_borrow_in  (w_borrow[gi]),
      .o_borrow_out (w_borrow[gi+1]),
      .o_digit      (w_count[gi*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load && !w_load_zero) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_load) begin
          w_state_nxt = w_load_zero ? ST_IDLE : ST_RUN;
        end else if (w_expire) begin
          w_state_nxt = w_reload_fire ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_expire;
    end
  end

  always_comb begin
    o_busy  = (r_state == ST_RUN);
    o_count = w_count;
    o_tc    = is_zero(64'(w_count));
    o_done  = r_done;
  end

endmodule

// File: tb/tb_parameterized_decade_down_counter.sv
// Directed-vector bench for the BCD countdown counter, WIDTH=4 MODULO=10 DIGITS=2.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
module tb_parameterized_decade_down_counter;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [7:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int unsigned n_total;
  int unsigned n_bad;

  parameterized_decade_down_counter #(
    .WIDTH  (4),
    .MODULO (10),
    .DIGITS (2)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_load        (load),
    .i_load_value  (load_value),
    .i_enable      (enable),
    .i_auto_reload (auto_reload),
    .o_count       (count),
    .o_busy        (busy),
    .o_tc          (tc),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned bcd(input int unsigned v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk_all(input string tag, input int unsigned c, input int unsigned b,
                         input int unsigned t, input int unsigned d);
    chk({tag, ".count"}, count, c);
    chk({tag, ".busy"},  busy,  b);
    chk({tag, ".tc"},    tc,    t);
    chk({tag, ".done"},  done,  d);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    load        = 1'b0;
    load_value  = 8'h00;
    enable      = 1'b1;
    auto_reload = 1'b0;

    // reset, then idle with enable high
    #12;
    chk_all("rst", 8'h00, 0, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_all("idle", 8'h00, 0, 1, 0);

    // load 23, count down to zero
    load = 1'b1; load_value = 8'h23;
    tick();
    load = 1'b0;
    chk_all("ld23", 8'h23, 1, 0, 0);
    for (int k = 1; k <= 23; k++) begin
      tick();
      chk("dn.count", count, bcd(23 - k));
      chk("dn.done",  done,  (k == 23) ? 1 : 0);
      chk("dn.busy",  busy,  (k == 23) ? 0 : 1);
      chk("dn.tc",    tc,    (k == 23) ? 1 : 0);
    end
    tick();
    chk_all("post", 8'h00, 0, 1, 0);

    // clamping and zero load
    load = 1'b1; load_value = 8'h9F;
    tick();
    chk_all("ld9F", 8'h99, 1, 0, 0);
    load_value = 8'h00;
    tick();
    chk_all("ld00", 8'h00, 0, 1, 0);
    load = 1'b0;
    tick();
    chk_all("ld00b", 8'h00, 0, 1, 0);

    // enable gating, then restart mid-run
    load = 1'b1; load_value = 8'h05; enable = 1'b1;
    tick();
    load = 1'b0;
    chk("g05", count, 8'h05);
    tick();
    chk("g04", count, 8'h04);
    enable = 1'b0;
    tick();
    chk("hold1", count, 8'h04);
    tick();
    chk("hold2", count, 8'h04);
    enable = 1'b1;
    tick();
    chk("g03", count, 8'h03);
    load = 1'b1; load_value = 8'h12;
    tick();
    load = 1'b0; enable = 1'b0;
    chk_all("rl12", 8'h12, 1, 0, 0);
    tick();
    chk_all("rl12b", 8'h12, 1, 0, 0);

    // asynchronous reset mid-run
    load = 1'b1; load_value = 8'h07; enable = 1'b1;
    tick();
    load = 1'b0;
    chk("r07", count, 8'h07);
    rst_n = 1'b0;
    #1;
    chk_all("arst", 8'h00, 0, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("arst2", 8'h00, 0, 1, 0);

`ifdef DECADE_DOWN_AUTORELOAD_EN
    auto_reload = 1'b1;
    load = 1'b1; load_value = 8'h03;
    tick();
    load = 1'b0;
    chk("ar03", count, 8'h03);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("ar.count", count, ((k % 3) == 0) ? 3 : 3 - (k % 3));
      chk("ar.done",  done,  ((k % 3) == 0) ? 1 : 0);
      chk("ar.busy",  busy,  1);
      chk("ar.tc",    tc,    0);
    end
    auto_reload = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
